mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine; consumes EX/MEM register outputs (MEM_READ/MEM_WRITE, FUNCT3, ALU result, rs2 data).
//  Drives a multi-cycle word-wide data memory over a req/ack handshake.
//  Stretches BUSYWAIT to freeze the pipeline registers until the access completes.
//  Returns aligned, sign/zero-extended load data toward MEM/WB; flags misaligned, illegal and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in ACCESS without MEM_ACK before MEM_FAULT; 0 disables the timeout
//  CNT_W           7   timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RESET        in   1   reset, synchronous, active-high
//  MEM_READ     in   1   load request from EX/MEM
//  MEM_WRITE    in   1   store request from EX/MEM
//  FUNCT3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ADDRESS      in   32  byte address (ALU result)
//  WRITE_DATA   in   32  store data (rs2), right-aligned
//  LOAD_DATA    out  32  extended load result, registered
//  BUSYWAIT     out  1   pipeline stall, combinational
//  MISALIGNED   out  1   one-cycle pulse: misaligned H/W access, no memory request issued
//  MEM_FAULT    out  1   one-cycle pulse: illegal FUNCT3, read+write both set, or timeout
//  DM_RD_REQ    out  1   memory read request, held until ack
//  DM_WR_REQ    out  1   memory write request, held until ack
//  DM_ADDR      out  30  word address = ADDRESS[31:2]
//  DM_WDATA     out  32  lane-replicated store data
//  DM_BYTE_EN   out  4   store byte lanes; 4'b1111 on reads
//  DM_RDATA     in   32  memory read word, valid with DM_ACK
//  DM_ACK       in   1   single-cycle completion strobe
// BEHAVIOUR
//  Reset: state IDLE, counter 0; LOAD_DATA, MISALIGNED, MEM_FAULT, DM_RD_REQ, DM_WR_REQ, DM_ADDR,
//   DM_WDATA, DM_BYTE_EN all 0. BUSYWAIT 0 while RESET is high.
//  Legality (IDLE only), with req = MEM_READ|MEM_WRITE:
//   - both set, or FUNCT3 not in {000,001,010} for stores / {000,001,010,100,101} for loads
//     -> MEM_FAULT pulse next cycle.
//   - H with ADDRESS[0]!=0, or W with ADDRESS[1:0]!=0 -> MISALIGNED pulse next cycle.
//   - In both cases: no request issued, BUSYWAIT stays 0, state stays IDLE.
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//   - IDLE: legal req -> BUSYWAIT=1 combinationally in the same cycle; at the edge, latch DM_ADDR/
//     DM_WDATA/DM_BYTE_EN/funct3/addr[1:0], raise DM_RD_REQ or DM_WR_REQ, clear counter, go ACCESS.
//   - ACCESS: BUSYWAIT=1, request and all DM_* outputs held stable.
//     - DM_ACK=1: drop request; on reads, latch extended LOAD_DATA; go DONE.
//     - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: drop request, MEM_FAULT pulse,
//       go DONE, LOAD_DATA unchanged.
//     - Else: counter increments.
//   - DONE: BUSYWAIT=0 for exactly one cycle so EX/MEM advances. Inputs are ignored this cycle
//     (no re-issue of the completed access); go IDLE.
//  Minimum access latency: BUSYWAIT high for N+1 cycles when DM_ACK arrives N cycles after the request rises.
//  Store lanes (o = ADDRESS[1:0]):
//   - SB: BYTE_EN = 4'b0001<<o, WDATA = {4{WRITE_DATA[7:0]}}
//   - SH: BYTE_EN = 4'b0011<<o, WDATA = {2{WRITE_DATA[15:0]}}
//   - SW: BYTE_EN = 4'b1111, WDATA = WRITE_DATA
//  Load extract: byte = DM_RDATA[8*o+:8], half = DM_RDATA[16*o[1]+:16].
//   B/H sign-extend; BU/HU zero-extend; W unchanged.
//  LOAD_DATA holds its value until the next successful load; stores and faults do not alter it.
//  DM_ACK outside ACCESS is ignored.
//  RESET mid-ACCESS: request dropped at that edge, state IDLE; a late DM_ACK is ignored.
// TESTING
//  1. LB at 0x0000_0103, DM_RDATA=0x80FF_1234, ack after 1 cycle -> LOAD_DATA=0xFFFF_FF80, BUSYWAIT high 2 cycles.
//  2. LHU at 0x102, DM_RDATA=0x80FF_1234 -> LOAD_DATA=0x0000_80FF. LH at the same address -> 0xFFFF_80FF.
//  3. SB at 0x101, WRITE_DATA=0x1234_56AB -> DM_BYTE_EN=4'b0010, DM_WDATA=0xABAB_ABAB, DM_ADDR=0x40;
//     SW at 0x100 -> 4'b1111.
//  4. LW at 0x102 -> MISALIGNED pulse, DM_RD_REQ never rises, BUSYWAIT 0.
//     FUNCT3=011 load -> MEM_FAULT pulse, no request.
//  5. TIMEOUT_CYCLES=4, no ack -> request drops after 4 ACCESS cycles, MEM_FAULT pulse,
//     DONE cycle seen, LOAD_DATA unchanged.
//  6. RESET asserted 2 cycles into ACCESS, then DM_ACK -> outputs 0, state IDLE, ack ignored;
//     next legal load completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus between the MEM-stage access unit (master)
// and the multi-cycle data memory (slave).
interface mem_access_unit_if;
    logic        DM_RD_REQ;
    logic        DM_WR_REQ;
    logic [29:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [3:0]  DM_BYTE_EN;
    logic [31:0] DM_RDATA;
    logic        DM_ACK;

    modport master (
        output DM_RD_REQ, DM_WR_REQ, DM_ADDR, DM_WDATA, DM_BYTE_EN,
        input  DM_RDATA, DM_ACK
    );

    modport slave (
        input  DM_RD_REQ, DM_WR_REQ, DM_ADDR, DM_WDATA, DM_BYTE_EN,
        output DM_RDATA, DM_ACK
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: stalls the pipeline while a word-wide memory
// access is in flight and returns aligned, extended load data.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic [2:0]        FUNCT3,
    input  logic [31:0]       ADDRESS,
    input  logic [31:0]       WRITE_DATA,
    output logic [31:0]       LOAD_DATA,
    output logic              BUSYWAIT,
    output logic              MISALIGNED,
    output logic              MEM_FAULT,
    mem_access_unit_if.master dm
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;

    logic             req;
    logic             f3_ok;
    logic             illegal;
    logic             unaligned;
    logic             issue;
    logic [3:0]       st_en;
    logic [31:0]      st_data;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [31:0]      ext_data;
    logic             timeout_hit;

    // Classify the request presented by EX/MEM; only meaningful in IDLE.
    always_comb begin
        req = MEM_READ | MEM_WRITE;
        case (FUNCT3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~MEM_WRITE;
            default:                f3_ok = 1'b0;
        endcase
        illegal   = req & ((MEM_READ & MEM_WRITE) | ~f3_ok);
        unaligned = req & ~illegal &
                    (((FUNCT3[1:0] == 2'b01) & ADDRESS[0]) |
                     ((FUNCT3[1:0] == 2'b10) & (ADDRESS[1:0] != 2'b00)));
        issue     = req & ~illegal & ~unaligned;
    end

    always_comb begin
        st_en   = 4'b1111;
        st_data = WRITE_DATA;
        case (FUNCT3[1:0])
            2'b00: begin
                st_en   = 4'b0001 << ADDRESS[1:0];
                st_data = {4{WRITE_DATA[7:0]}};
            end
            2'b01: begin
                st_en   = 4'b0011 << ADDRESS[1:0];
                st_data = {2{WRITE_DATA[15:0]}};
            end
            default: begin
                st_en   = 4'b1111;
                st_data = WRITE_DATA;
            end
        endcase
        if (!MEM_WRITE) begin
            st_en = 4'b1111;
        end
    end

    // Load extraction uses the size/offset captured when the access was issued.
    always_comb begin
        lane_byte = dm.DM_RDATA[{off_q, 3'b000} +: 8];
        lane_half = dm.DM_RDATA[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ext_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  ext_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  ext_data = {24'b0, lane_byte};
            3'b101:  ext_data = {16'b0, lane_half};
            default: ext_data = dm.DM_RDATA;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign BUSYWAIT = ~RESET & ((state == ACCESS) | ((state == IDLE) & issue));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            funct3_q      <= '0;
            off_q         <= '0;
            LOAD_DATA     <= '0;
            MISALIGNED    <= 1'b0;
            MEM_FAULT     <= 1'b0;
            dm.DM_RD_REQ  <= 1'b0;
            dm.DM_WR_REQ  <= 1'b0;
            dm.DM_ADDR    <= '0;
            dm.DM_WDATA   <= '0;
            dm.DM_BYTE_EN <= '0;
        end else begin
            MISALIGNED <= 1'b0;
            MEM_FAULT  <= 1'b0;
            case (state)
                IDLE: begin
                    if (illegal) begin
                        MEM_FAULT <= 1'b1;
                    end else if (unaligned) begin
                        MISALIGNED <= 1'b1;
                    end else if (issue) begin
                        dm.DM_ADDR    <= ADDRESS[31:2];
                        dm.DM_WDATA   <= st_data;
                        dm.DM_BYTE_EN <= st_en;
                        dm.DM_RD_REQ  <= MEM_READ;
                        dm.DM_WR_REQ  <= MEM_WRITE;
                        funct3_q      <= FUNCT3;
                        off_q         <= ADDRESS[1:0];
                        cnt           <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dm.DM_ACK) begin
                        dm.DM_RD_REQ <= 1'b0;
                        dm.DM_WR_REQ <= 1'b0;
                        if (dm.DM_RD_REQ) begin
                            LOAD_DATA <= ext_data;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        dm.DM_RD_REQ <= 1'b0;
                        dm.DM_WR_REQ <= 1'b0;
                        MEM_FAULT    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: a transaction-level model predicts
// every output each cycle and one negedge process compares the DUT to it.
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        CLK;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] LOAD_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        MEM_FAULT;

    mem_access_unit_if dm();

    mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .LOAD_DATA(LOAD_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
        .MEM_FAULT(MEM_FAULT), .dm(dm)
    );

    int assertCount = 0;
    int failCount   = 0;

    bit          chkEn = 0;
    bit          expBusy, expRd, expWr, expMis, expFlt, expBus, expWdChk;
    logic [31:0] expLoad;
    logic [29:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;

    int          busyRun = 0;
    int          lastBusyLen = 0;
    logic [3:0]  capBe;
    logic [31:0] capWd;
    logic [29:0] capAddr;
    logic        capMis, capFlt;
    logic [31:0] capLoad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic setQuiet();
        expBusy = 0; expRd = 0; expWr = 0; expMis = 0; expFlt = 0;
        expBus = 0; expWdChk = 0;
    endtask

    // Reference load result: shift the addressed lane down, mask, then extend.
    function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] w;
        int v;
        w = word >> (8 * off);
        case (f3)
            3'd0: begin v = int'(w & 32'hFF);   if (v > 127)   v -= 256;   end
            3'd1: begin v = int'(w & 32'hFFFF); if (v > 32767) v -= 65536; end
            3'd4: v = int'(w & 32'hFF);
            3'd5: v = int'(w & 32'hFFFF);
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    // One pipeline request plus the memory's response; ackDelay beyond TIMEOUT means no ack.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ackDelay);
        bit f3Legal, isFault, isMis, timedOut;
        int size;
        logic [3:0] be;
        logic [31:0] wd;
        capMis = 0; capFlt = 0;
        f3Legal = (f3 <= 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
        isFault = (rd | wr) && ((rd & wr) || !f3Legal);
        size    = 1 << f3[1:0];
        isMis   = (rd | wr) && !isFault && ((int'(addr[1:0]) % size) != 0);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITE_DATA = wdata;
        dm.DM_ACK = 0;
        setQuiet();
        expBusy = (rd | wr) && !isFault && !isMis;
        if (!(rd | wr)) begin
            dm.DM_ACK = 1'($urandom_range(0, 1));
            dm.DM_RDATA = $urandom;
            step();
            return;
        end
        if (isFault || isMis) begin
            step();
            MEM_READ = 0; MEM_WRITE = 0;
            setQuiet();
            expFlt = isFault; expMis = isMis;
            capMis = MISALIGNED; capFlt = MEM_FAULT;
            step();
            return;
        end
        be = 4'b0000;
        for (int i = 0; i < size; i++) be[int'(addr[1:0]) + i] = 1'b1;
        if (rd) be = 4'b1111;
        if (size == 1)      wd = (wdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) wd = (wdata & 32'hFFFF) * 32'h0001_0001;
        else                wd = wdata;
        step();
        timedOut = 1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            setQuiet();
            expBusy = 1; expRd = rd; expWr = wr; expBus = 1; expWdChk = wr;
            expAddr = addr[31:2]; expBe = be; expWdata = wd;
            dm.DM_ACK = (k == ackDelay);
            dm.DM_RDATA = (k == ackDelay) ? rdata : $urandom;
            if (k == 1) begin
                capBe = dm.DM_BYTE_EN; capWd = dm.DM_WDATA; capAddr = dm.DM_ADDR;
            end
            step();
            if (k == ackDelay) begin
                timedOut = 0;
                break;
            end
        end
        setQuiet();
        dm.DM_ACK = (ackDelay == TIMEOUT + 1);
        dm.DM_RDATA = $urandom;
        expFlt = timedOut;
        if (!timedOut && rd) expLoad = loadModel(f3, addr[1:0], rdata);
        capFlt = MEM_FAULT;
        step();
    endtask

    task automatic resetMidAccess();
        MEM_READ = 1; MEM_WRITE = 0; FUNCT3 = 3'b010; ADDRESS = 32'h300; WRITE_DATA = 0;
        dm.DM_ACK = 0;
        setQuiet(); expBusy = 1;
        step();
        for (int k = 1; k <= 2; k++) begin
            setQuiet();
            expBusy = 1; expRd = 1; expBus = 1; expAddr = 30'hC0; expBe = 4'b1111;
            step();
        end
        RESET = 1; MEM_READ = 0;
        setQuiet(); expRd = 1; expBus = 1; expAddr = 30'hC0; expBe = 4'b1111;
        step();
        RESET = 0;
        dm.DM_ACK = 1; dm.DM_RDATA = 32'h1234_5678;
        setQuiet(); expBus = 1; expWdChk = 1; expAddr = 0; expBe = 0; expWdata = 0; expLoad = 0;
        step();
        dm.DM_ACK = 0;
        capLoad = LOAD_DATA;
        step();
    endtask

    // Single compare point: every output against the model, mid-cycle.
    always @(negedge CLK) begin
        if (chkEn) begin
            checkOutput("BUSYWAIT",   BUSYWAIT,     expBusy);
            checkOutput("MISALIGNED", MISALIGNED,   expMis);
            checkOutput("MEM_FAULT",  MEM_FAULT,    expFlt);
            checkOutput("DM_RD_REQ",  dm.DM_RD_REQ, expRd);
            checkOutput("DM_WR_REQ",  dm.DM_WR_REQ, expWr);
            checkOutput("LOAD_DATA",  LOAD_DATA,    expLoad);
            if (expBus) begin
                checkOutput("DM_ADDR",    dm.DM_ADDR,    expAddr);
                checkOutput("DM_BYTE_EN", dm.DM_BYTE_EN, expBe);
            end
            if (expWdChk) checkOutput("DM_WDATA", dm.DM_WDATA, expWdata);
            if (BUSYWAIT) busyRun++;
            else begin
                if (busyRun != 0) lastBusyLen = busyRun;
                busyRun = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET = 1; MEM_READ = 0; MEM_WRITE = 0; FUNCT3 = 0; ADDRESS = 0; WRITE_DATA = 0;
        dm.DM_ACK = 0; dm.DM_RDATA = 0;
        step();
        setQuiet();
        expBus = 1; expWdChk = 1; expAddr = 0; expBe = 0; expWdata = 0; expLoad = 0;
        chkEn = 1;
        step();
        RESET = 0;
        step();
        setQuiet();

        applyStimulus(1, 0, 3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 1);
        checkOutput("pin LB data", LOAD_DATA, 32'hFFFF_FF80);
        checkOutput("pin LB busy len", lastBusyLen, 2);
        applyStimulus(1, 0, 3'b101, 32'h102, 0, 32'h80FF_1234, 2);
        checkOutput("pin LHU data", LOAD_DATA, 32'h0000_80FF);
        checkOutput("pin LHU busy len", lastBusyLen, 3);
        applyStimulus(1, 0, 3'b001, 32'h102, 0, 32'h80FF_1234, 1);
        checkOutput("pin LH data", LOAD_DATA, 32'hFFFF_80FF);
        applyStimulus(0, 1, 3'b000, 32'h101, 32'h1234_56AB, 0, 1);
        checkOutput("pin SB byte_en", capBe, 4'b0010);
        checkOutput("pin SB wdata", capWd, 32'hABAB_ABAB);
        checkOutput("pin SB addr", capAddr, 30'h40);
        applyStimulus(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 2);
        checkOutput("pin SW byte_en", capBe, 4'b1111);
        checkOutput("pin SW wdata", capWd, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b010, 32'h102, 0, 0, 1);
        checkOutput("pin LW misaligned", capMis, 1'b1);
        applyStimulus(1, 0, 3'b011, 32'h100, 0, 0, 1);
        checkOutput("pin f3=011 fault", capFlt, 1'b1);
        applyStimulus(1, 0, 3'b010, 32'h200, 0, 32'h1111_1111, TIMEOUT + 2);
        checkOutput("pin timeout fault", capFlt, 1'b1);
        checkOutput("pin timeout busy len", lastBusyLen, TIMEOUT + 1);
        checkOutput("pin timeout load kept", LOAD_DATA, 32'hFFFF_80FF);
        resetMidAccess();
        checkOutput("pin reset load", capLoad, 32'h0);
        applyStimulus(1, 0, 3'b010, 32'h104, 0, 32'hCAFE_F00D, 1);
        checkOutput("pin post-reset LW", LOAD_DATA, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            int kind;
            logic rd, wr;
            logic [2:0] f3;
            int dly;
            kind = $urandom_range(0, 9);
            rd = 0; wr = 0;
            if (kind == 1) begin rd = 1; wr = 1; end
            else if (kind >= 2) begin
                rd = kind[0];
                wr = !kind[0];
            end
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 2)
                                              : $urandom_range(1, 3);
            applyStimulus(rd, wr, f3, $urandom, $urandom, $urandom, dly);
        end
        applyStimulus(0, 0, 3'b000, 0, 0, 0, 1);
        applyStimulus(0, 0, 3'b000, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
